// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : wb_arb_pkg
// Purpose: Shared types and helpers for the Wishbone bus arbiter.
//          - arb_state_t : arbiter FSM state encoding
//          - rr_pick()   : rotating-priority search returning the winner index
// Rev    : 1.0  initial release
// ============================================================================
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    FLUSH = 2'd2
  } arb_state_t;

  // Upper bound on the number of requesters the arbiter supports.
  localparam int MAX_MASTERS = 8;
  localparam int MAX_IDX_W   = $clog2(MAX_MASTERS);

  // Search req starting at last+1 and wrapping at n; returns the first
  // requester found or -1 when nothing is requesting. The loop has a constant
  // bound so it unrolls cleanly; the n limit is applied inside.
  function automatic int rr_pick(input logic [MAX_MASTERS-1:0] req,
                                 input int                     last,
                                 input int                     n);
    int                   res;
    int                   k;
    logic [MAX_IDX_W-1:0] k_idx;
    res = -1;
    for (int i = 1; i <= MAX_MASTERS; i++) begin
      if (i <= n && res < 0) begin
        k     = (last + i) % n;
        k_idx = k[MAX_IDX_W-1:0];
        if (req[k_idx]) res = k;
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_rr_picker.sv
`default_nettype none
// ============================================================================
// Module : wb_rr_picker
// Purpose: Combinational round-robin picker. Rotates the request vector so
//          the master after 'last' has highest priority and priority-encodes.
// Ports  : req   [NUM_MASTERS] in  - request levels
//          last  [IDX_W]       in  - index of the previous owner
//          gnt   [NUM_MASTERS] out - one-hot winner (0 when no request)
//          idx   [IDX_W]       out - winner index
//          valid               out - any request present
// Rev    : 1.0  initial release
// ============================================================================
module wb_rr_picker
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int IDX_W       = 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       last,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [IDX_W-1:0]       idx,
  output logic                   valid
);

  logic [MAX_MASTERS-1:0] req_pad;
  int                     pick;

  always_comb begin
    req_pad                    = '0;
    req_pad[NUM_MASTERS-1:0]   = req;
    pick                       = rr_pick(req_pad, int'(last), NUM_MASTERS);
    valid                      = (pick >= 0);
    idx                        = valid ? IDX_W'(pick) : '0;
    gnt                        = valid ? (NUM_MASTERS'(1) << idx) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/wb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : wb_bus_arbiter
// Purpose: Shares one Wishbone slave between NUM_MASTERS requesters using
//          round-robin arbitration. A grant is held for as long as the owner
//          keeps cyc high; a watchdog aborts strobes the slave never acks.
// Ports  : clk_i, rst_i (async, active-low)
//          m_cyc_i/m_stb_i/m_we_i/m_adr_i/m_dat_i : packed master requests
//          m_ack_o/m_err_o/m_dat_o                : master responses
//          gnt_o                                  : one-hot current grant
//          s_cyc_o/s_stb_o/s_we_o/s_adr_o/s_dat_o : slave-side request
//          s_ack_i/s_dat_i                        : slave response
// Rev    : 1.0  initial release
// ============================================================================
module wb_bus_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 2,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic [DATA_WIDTH-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]            gnt_o,
  output logic                              s_cyc_o,
  output logic                              s_stb_o,
  output logic                              s_we_o,
  output logic [ADDR_WIDTH-1:0]             s_adr_o,
  output logic [DATA_WIDTH-1:0]             s_dat_o,
  input  logic                              s_ack_i,
  input  logic [DATA_WIDTH-1:0]             s_dat_i
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_MASTERS - 1);
  // Terminal count: the timeout fires on the edge that would reach TIMEOUT_CYCLES.
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  arb_state_t             state;
  logic [NUM_MASTERS-1:0] gnt;
  logic [IDX_W-1:0]       gidx;
  logic [IDX_W-1:0]       last;
  logic [WD_W-1:0]        wdog;
  logic [NUM_MASTERS-1:0] err;

  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_valid;
  logic                   busy;

  wb_rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_picker (
    .req   (m_cyc_i),
    .last  (last),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      gnt   <= '0;
      gidx  <= '0;
      last  <= LAST_RST;
      wdog  <= '0;
      err   <= '0;
    end else begin
      err <= '0;
      case (state)
        IDLE: begin
          wdog <= '0;
          if (pick_valid) begin
            gnt   <= pick_gnt;
            gidx  <= pick_idx;
            state <= BUSY;
          end
        end

        BUSY: begin
          // The owner leaving takes precedence: a master that has dropped cyc
          // is no longer waiting, so no error is reported to it.
          if (!m_cyc_i[gidx]) begin
            state <= IDLE;
            gnt   <= '0;
            last  <= gidx;
            wdog  <= '0;
          end else if (s_ack_i) begin
            wdog <= '0;
          end else if (m_stb_i[gidx] && (TIMEOUT_CYCLES != 0)) begin
            if (wdog == WD_LAST) begin
              state <= FLUSH;
              err   <= gnt;
              wdog  <= '0;
            end else begin
              wdog <= wdog + 1'b1;
            end
          end
        end

        FLUSH: begin
          // Grant stays parked on the aborted master until it gives up cyc.
          // The pointer advances here too so an aborted owner goes to the back.
          if (!m_cyc_i[gidx]) begin
            state <= IDLE;
            gnt   <= '0;
            last  <= gidx;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == BUSY);

  // Slave side follows the owner combinationally only while BUSY; IDLE and
  // FLUSH present an idle bus, which also hides any late ack.
  assign s_cyc_o = busy & m_cyc_i[gidx];
  assign s_stb_o = busy & m_stb_i[gidx];
  assign s_we_o  = busy & m_we_i[gidx];
  assign s_adr_o = busy ? m_adr_i[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign s_dat_o = busy ? m_dat_i[int'(gidx)*DATA_WIDTH +: DATA_WIDTH] : '0;

  assign m_ack_o = busy ? (gnt & {NUM_MASTERS{s_ack_i}}) : '0;
  assign m_err_o = err;
  assign m_dat_o = s_dat_i;
  assign gnt_o   = gnt;

  a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (!rst_i) $onehot0(gnt_o));
  a_cyc_has_gnt: assert property (@(posedge clk_i) disable iff (!rst_i) s_cyc_o |-> (gnt_o != '0));
  a_ack_onehot0: assert property (@(posedge clk_i) disable iff (!rst_i) $onehot0(m_ack_o));

endmodule
`default_nettype wire

// File: tb/tb_wb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_wb_bus_arbiter
// Purpose: Directed self-checking bench for wb_bus_arbiter (4 masters,
//          8-cycle watchdog). Inputs change and outputs are sampled on the
//          falling clock edge.
// Rev    : 1.0  initial release
// ============================================================================
module tb_wb_bus_arbiter;

  localparam int N  = 4;
  localparam int AW = 2;
  localparam int DW = 8;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    m_cyc, m_stb, m_we;
  logic [N*AW-1:0] m_adr;
  logic [N*DW-1:0] m_dat;
  logic [N-1:0]    m_ack, m_err, gnt;
  logic [DW-1:0]   m_rdat;
  logic            s_cyc, s_stb, s_we, s_ack;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_wdat, s_rdat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_bus_arbiter #(
    .NUM_MASTERS    (N),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .m_cyc_i (m_cyc),
    .m_stb_i (m_stb),
    .m_we_i  (m_we),
    .m_adr_i (m_adr),
    .m_dat_i (m_dat),
    .m_ack_o (m_ack),
    .m_err_o (m_err),
    .m_dat_o (m_rdat),
    .gnt_o   (gnt),
    .s_cyc_o (s_cyc),
    .s_stb_o (s_stb),
    .s_we_o  (s_we),
    .s_adr_o (s_adr),
    .s_dat_o (s_wdat),
    .s_ack_i (s_ack),
    .s_dat_i (s_rdat)
  );

  task automatic clear_inputs();
    m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0;
    s_ack = 1'b0; s_rdat = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt: got %b expected 0000", gnt); end
    checks++; if ({s_cyc, s_stb, s_we} !== 3'b000) begin errors++; $display("FAIL rst_ctl: got %b expected 000", {s_cyc, s_stb, s_we}); end
    checks++; if ({s_adr, s_wdat} !== 10'h000) begin errors++; $display("FAIL rst_adr_dat: got %h expected 000", {s_adr, s_wdat}); end
    checks++; if ({m_ack, m_err} !== 8'h00) begin errors++; $display("FAIL rst_ack_err: got %b expected 00000000", {m_ack, m_err}); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    do_reset();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1;
    m_adr[1*AW +: AW] = 2'd2; m_dat[1*DW +: DW] = 8'h5A;
    @(negedge clk);
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL wr_gnt: got %b expected 0010", gnt); end
    checks++; if ({s_cyc, s_stb, s_we} !== 3'b111) begin errors++; $display("FAIL wr_ctl: got %b expected 111", {s_cyc, s_stb, s_we}); end
    checks++; if (s_adr !== 2'd2) begin errors++; $display("FAIL wr_adr: got %0d expected 2", s_adr); end
    checks++; if (s_wdat !== 8'h5A) begin errors++; $display("FAIL wr_dat: got %h expected 5a", s_wdat); end
    s_ack = 1'b1;
    #1;
    checks++; if (m_ack !== 4'b0010) begin errors++; $display("FAIL wr_ack: got %b expected 0010", m_ack); end
    @(negedge clk);
    s_ack = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_we[1] = 1'b0;
    #1;
    checks++; if (m_ack !== 4'b0000) begin errors++; $display("FAIL wr_ack_end: got %b expected 0000", m_ack); end
    @(negedge clk);
    checks++; if ({gnt, s_cyc} !== 5'b00000) begin errors++; $display("FAIL wr_release: got %b expected 00000", {gnt, s_cyc}); end
  endtask

  task automatic test_two_reads();
    do_reset();
    m_cyc = 4'b0011; m_stb = 4'b0011; m_we = 4'b0000;
    m_adr[0*AW +: AW] = 2'd1; m_adr[1*AW +: AW] = 2'd3;
    @(negedge clk);
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rd_first_gnt: got %b expected 0001", gnt); end
    checks++; if ({s_cyc, s_we, s_adr} !== 4'b1001) begin errors++; $display("FAIL rd0_bus: got %b expected 1001", {s_cyc, s_we, s_adr}); end
    s_ack = 1'b1; s_rdat = 8'hC3;
    #1;
    checks++; if (m_ack !== 4'b0001) begin errors++; $display("FAIL rd0_ack: got %b expected 0001", m_ack); end
    checks++; if (m_rdat !== 8'hC3) begin errors++; $display("FAIL rd0_dat: got %h expected c3", m_rdat); end
    @(negedge clk);
    s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    @(negedge clk);
    checks++; if ({gnt, s_cyc} !== 5'b00000) begin errors++; $display("FAIL rd_gap: got %b expected 00000", {gnt, s_cyc}); end
    @(negedge clk);
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rd_second_gnt: got %b expected 0010", gnt); end
    checks++; if ({s_cyc, s_adr} !== 3'b111) begin errors++; $display("FAIL rd1_bus: got %b expected 111", {s_cyc, s_adr}); end
    // Ack and cyc drop together: the ack must still reach master 1.
    s_ack = 1'b1; s_rdat = 8'h3C; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    #1;
    checks++; if (m_ack !== 4'b0010) begin errors++; $display("FAIL rd1_ack: got %b expected 0010", m_ack); end
    checks++; if (m_rdat !== 8'h3C) begin errors++; $display("FAIL rd1_dat: got %h expected 3c", m_rdat); end
    @(negedge clk);
    s_ack = 1'b0;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rd1_release: got %b expected 0000", gnt); end
  endtask

  task automatic test_fairness();
    logic [N-1:0] exp_gnt;
    do_reset();
    m_cyc = 4'b1111; m_stb = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      exp_gnt = 4'b0001 << (t % N);
      checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", t, gnt, exp_gnt); end
      s_ack = 1'b1; m_cyc = m_cyc & ~exp_gnt; m_stb = m_stb & ~exp_gnt;
      #1;
      checks++; if (m_ack !== exp_gnt) begin errors++; $display("FAIL rr_ack[%0d]: got %b expected %b", t, m_ack, exp_gnt); end
      @(negedge clk);
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rr_gap[%0d]: got %b expected 0000", t, gnt); end
      s_ack = 1'b0; m_cyc = 4'b1111; m_stb = 4'b1111;
    end
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_dat;
    do_reset();
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1; m_we[2] = 1'b1;
    m_adr[0*AW +: AW] = 2'd3;
    @(negedge clk);
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      exp_dat = 8'h11 * (j + 1);
      m_adr[2*AW +: AW] = j[1:0]; m_dat[2*DW +: DW] = exp_dat;
      #1;
      checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL lock_gnt[%0d]: got %b expected 0100", j, gnt); end
      checks++; if ({s_cyc, s_we, s_adr, s_wdat} !== {2'b11, j[1:0], exp_dat}) begin
        errors++; $display("FAIL lock_wr[%0d]: got %h expected %h", j, {s_cyc, s_we, s_adr, s_wdat}, {2'b11, j[1:0], exp_dat});
      end
      s_ack = 1'b1;
      #1;
      checks++; if (m_ack !== 4'b0100) begin errors++; $display("FAIL lock_ack[%0d]: got %b expected 0100", j, m_ack); end
      @(negedge clk);
    end
    s_ack = 1'b0; m_cyc[2] = 1'b0; m_stb[2] = 1'b0; m_we[2] = 1'b0;
    @(negedge clk);
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL lock_gap: got %b expected 0000", gnt); end
    @(negedge clk);
    checks++; if ({gnt, s_adr} !== 6'b000111) begin errors++; $display("FAIL lock_next: got %b expected 000111", {gnt, s_adr}); end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_timeout();
    do_reset();
    m_cyc = 4'b1010; m_stb[1] = 1'b1;
    @(negedge clk);
    checks++; if ({gnt, s_stb} !== 5'b00101) begin errors++; $display("FAIL to_start: got %b expected 00101", {gnt, s_stb}); end
    for (int i = 1; i < TO; i++) begin
      @(negedge clk);
      checks++; if ({m_err, s_stb} !== 5'b00001) begin errors++; $display("FAIL to_wait[%0d]: got %b expected 00001", i, {m_err, s_stb}); end
    end
    @(negedge clk);
    checks++; if (m_err !== 4'b0010) begin errors++; $display("FAIL to_err: got %b expected 0010", m_err); end
    checks++; if ({s_cyc, s_stb, gnt} !== 6'b000010) begin errors++; $display("FAIL to_flush: got %b expected 000010", {s_cyc, s_stb, gnt}); end
    @(negedge clk);
    checks++; if (m_err !== 4'b0000) begin errors++; $display("FAIL to_err_pulse: got %b expected 0000", m_err); end
    s_ack = 1'b1;
    #1;
    checks++; if (m_ack !== 4'b0000) begin errors++; $display("FAIL to_late_ack: got %b expected 0000", m_ack); end
    @(negedge clk);
    s_ack = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    @(negedge clk);
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL to_release: got %b expected 0000", gnt); end
    @(negedge clk);
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL to_next_gnt: got %b expected 1000", gnt); end
    // Ack arriving on the last stall cycle must beat the timeout.
    m_stb[3] = 1'b1;
    repeat (TO - 1) @(negedge clk);
    s_ack = 1'b1;
    #1;
    checks++; if (m_ack !== 4'b1000) begin errors++; $display("FAIL to_edge_ack: got %b expected 1000", m_ack); end
    @(negedge clk);
    s_ack = 1'b0;
    checks++; if ({m_err, s_cyc} !== 5'b00001) begin errors++; $display("FAIL to_ack_wins: got %b expected 00001", {m_err, s_cyc}); end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1;
    m_adr[1*AW +: AW] = 2'd3; m_dat[1*DW +: DW] = 8'hA5;
    @(negedge clk);
    m_cyc[0] = 1'b1; s_ack = 1'b1;
    #1;
    checks++; if (m_ack !== 4'b0010) begin errors++; $display("FAIL mid_busy: got %b expected 0010", m_ack); end
    rst_n = 1'b0;
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL mid_gnt: got %b expected 0000", gnt); end
    checks++; if ({s_cyc, s_stb, s_we, s_adr, s_wdat} !== 13'h0) begin
      errors++; $display("FAIL mid_slave: got %h expected 0", {s_cyc, s_stb, s_we, s_adr, s_wdat});
    end
    checks++; if ({m_ack, m_err} !== 8'h00) begin errors++; $display("FAIL mid_ack_err: got %b expected 00000000", {m_ack, m_err}); end
    @(negedge clk);
    rst_n = 1'b1; s_ack = 1'b0;
    @(negedge clk);
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mid_first_gnt: got %b expected 0001", gnt); end
    clear_inputs();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_two_reads();
    test_fairness();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
